// File: rtl/fifo_ctrlread_param_if.sv
// Write/read port bundle for fifo_ctrlread_param; master is the user side, slave is the FIFO.
interface fifo_ctrlread_param_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 17
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  valid;
  logic                  full;
  logic                  empty;
  logic                  prog_full;
  logic                  prog_empty;
  logic [CNT_WIDTH-1:0]  data_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, valid, full, empty, prog_full, prog_empty, data_count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, valid, full, empty, prog_full, prog_empty, data_count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrlread_param.sv
// Synchronous FIFO with any depth 2..4096, programmable flags and overflow/underflow pulses.
// Define FIFO_CTRLREAD_FWFT_EN for first-word-fall-through output; default is registered read data.
module fifo_ctrlread_param #(
  parameter int DATA_WIDTH        = 64,
  parameter int DEPTH             = 17,
  parameter int PROG_FULL_THRESH  = DEPTH - 2,
  parameter int PROG_EMPTY_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 srst,
  fifo_ctrlread_param_if.slave bus
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  overflow_r;
  logic                  underflow_r;

  // Handshake: a write is taken on a clock edge when wr_en=1 and full=0, a read when
  // rd_en=1 and empty=0; both flags come from the count as it stood before that edge,
  // so a simultaneous read never makes room for a write into a full FIFO (and vice versa).
  assign full_w  = (count == CNT_WIDTH'(DEPTH));
  assign empty_w = (count == '0);
  assign wr_ok   = bus.wr_en & ~full_w & ~srst;
  assign rd_ok   = bus.rd_en & ~empty_w & ~srst;

  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.prog_full  = (int'(count) >= PROG_FULL_THRESH);
  assign bus.prog_empty = (int'(count) <= PROG_EMPTY_THRESH);
  assign bus.data_count = count;
  assign bus.overflow   = overflow_r;
  assign bus.underflow  = underflow_r;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= bus.wr_en & full_w;
      underflow_r <= bus.rd_en & empty_w;
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_CTRLREAD_FWFT_EN
  // Head entry is visible combinationally; forced to zero while empty so reset shows dout=0.
  assign bus.dout  = empty_w ? '0 : mem[rd_ptr];
  assign bus.valid = ~empty_w;
`else
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  valid_r;

  always_ff @(posedge clk) begin
    if (srst) begin
      dout_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= rd_ok;
      if (rd_ok) dout_r <= mem[rd_ptr];
    end
  end

  assign bus.dout  = dout_r;
  assign bus.valid = valid_r;
`endif
endmodule

// File: doc/fifo_ctrlread_param.md
FIFO_CTRLREAD_PARAM -- requirements
Module: fifo_ctrlread_param

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_WIDTH, default 64: bit width of din/dout.
REQ-003 Parameter DEPTH, default 17: number of entries; any value 2..4096 SHALL be supported, power of two not required.
REQ-004 Parameter PROG_FULL_THRESH, default DEPTH-2: occupancy at or above which prog_full asserts.
REQ-005 Parameter PROG_EMPTY_THRESH, default 2: occupancy at or below which prog_empty asserts.
REQ-006 Derived parameter CNT_WIDTH = $clog2(DEPTH+1): width of data_count.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 srst  input  1  synchronous active-high reset.
REQ-009 din  input  DATA_WIDTH  write data.
REQ-010 wr_en  input  1  write request.
REQ-011 rd_en  input  1  read request.
REQ-012 dout  output  DATA_WIDTH  read data.
REQ-013 valid  output  1  dout holds a freshly read word.
REQ-014 full / empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-015 prog_full / prog_empty  output  1 each  threshold flags.
REQ-016 data_count  output  CNT_WIDTH  current occupancy.
REQ-017 overflow / underflow  output  1 each  one-cycle pulse on rejected write / rejected read.

Function
REQ-018 A write SHALL be accepted iff wr_en=1 and full=0 in that cycle; a write while full SHALL be rejected even if a read is accepted in the same cycle.
REQ-019 A read SHALL be accepted iff rd_en=1 and empty=0; a read while empty SHALL be rejected even if a write is accepted in the same cycle.
REQ-020 Write and read pointers SHALL each advance by one per accepted operation and wrap from DEPTH-1 to 0.
REQ-021 data_count SHALL be a register updated at the clock edge: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-022 full, empty, prog_full and prog_empty SHALL be decoded from the registered data_count and reflect accepted operations one cycle after the edge.
REQ-023 overflow SHALL pulse high for exactly one cycle in the cycle after a rejected write; underflow likewise for a rejected read.
REQ-024 Standard mode: dout SHALL be registered and carry the word popped by an accepted read one cycle later, with valid high for that one cycle; dout SHALL hold its value otherwise.
REQ-025 Word order SHALL be strictly first-in first-out across any number of wrap-arounds.
REQ-026 Storage SHALL not be reset; only pointers, count, flags and output registers are.

Reset
REQ-027 While srst=1 at a clock edge: pointers=0, data_count=0, empty=1, prog_empty=1, full=0, prog_full=0, valid=0, overflow=0, underflow=0, dout=0.
REQ-028 srst SHALL take priority over simultaneous wr_en/rd_en; reset mid-operation SHALL discard all contents, and no write or read in the reset cycle SHALL take effect.

Configuration
REQ-029 Macro FIFO_CTRLREAD_FWFT_EN SHALL select first-word-fall-through mode.
REQ-030 With FIFO_CTRLREAD_FWFT_EN defined: dout SHALL present the head entry whenever empty=0, valid SHALL equal ~empty, and an accepted read pops the head so the next entry appears after the edge.
REQ-031 Without FIFO_CTRLREAD_FWFT_EN: standard mode per REQ-024.

Verification
REQ-032 Reset, then write 0x1..0x11 (17 words, DEPTH=17) -> full=1 after last edge, data_count=17, prog_full high from count 15; 18th write -> overflow pulse, count stays 17.
REQ-033 Empty FIFO, rd_en=1 one cycle -> underflow pulse next cycle, valid=0, data_count=0.
REQ-034 Full FIFO, wr_en=1 and rd_en=1 same cycle -> read accepted, write rejected, overflow pulse, data_count=16.
REQ-035 Continuous write/read of 100 incrementing words with DEPTH=17 -> output sequence identical to input across wrap-around; standard mode valid one cycle after each rd_en.
REQ-036 Write 5 words, assert srst for one cycle with wr_en=1 -> empty=1, data_count=0, next read underflows; with FIFO_CTRLREAD_FWFT_EN, post-reset first write shows on dout with valid=1 one cycle later.
